// File: rtl/control_funcion_conf.sv
// control_funcion_conf: button-driven configuration-mode FSM producing the one-hot funcion_conf code and field pointer.
// Optional inactivity timeout enabled by defining CONF_TIMEOUT_EN.
`default_nettype none

module control_funcion_conf #(
  parameter logic [31:0] TIMEOUT_CICLOS = 32'd500_000_000,
  parameter int          CNT_W          = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_hora,
  input  logic       btn_fecha,
  input  logic       btn_timer,
  input  logic       btn_campo,
  input  logic       btn_salir,
  output logic [2:0] funcion_conf,
  output logic [1:0] campo,
  output logic       conf_activa
);

  typedef enum logic [2:0] {
    REPOSO     = 3'b000,
    CONF_HORA  = 3'b001,
    CONF_FECHA = 3'b010,
    CONF_TIMER = 3'b100
  } estado_t;

  if ((64'd1 << CNT_W) <= {32'd0, TIMEOUT_CICLOS}) begin : g_cnt_w_check
    $error("CNT_W too small for TIMEOUT_CICLOS");
  end

  estado_t    estado, estado_nxt;
  logic [1:0] campo_nxt;
  logic [4:0] btn, prev, press;
  logic       any_press;

  // Bit order: salir, hora, fecha, timer, campo (highest priority first)
  assign btn       = {btn_salir, btn_hora, btn_fecha, btn_timer, btn_campo};
  assign press     = btn & ~prev;
  assign any_press = |press;

`ifdef CONF_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(TIMEOUT_CICLOS - 32'd1);
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  assign timeout = (estado != REPOSO) && (cnt == CNT_FIN);
`endif

  always_comb begin
    estado_nxt = estado;
    campo_nxt  = campo;
    if (press[4]) begin
      estado_nxt = REPOSO;
      campo_nxt  = 2'd0;
    end else if (press[3]) begin
      estado_nxt = (estado == CONF_HORA) ? REPOSO : CONF_HORA;
      campo_nxt  = 2'd0;
    end else if (press[2]) begin
      estado_nxt = (estado == CONF_FECHA) ? REPOSO : CONF_FECHA;
      campo_nxt  = 2'd0;
    end else if (press[1]) begin
      estado_nxt = (estado == CONF_TIMER) ? REPOSO : CONF_TIMER;
      campo_nxt  = 2'd0;
    end else if (press[0]) begin
      case (estado)
        CONF_HORA, CONF_TIMER: campo_nxt = (campo == 2'd2) ? 2'd0 : campo + 2'd1;
        CONF_FECHA:            campo_nxt = campo + 2'd1;
        default:               campo_nxt = 2'd0;
      endcase
    end
`ifdef CONF_TIMEOUT_EN
    else if (timeout) begin
      estado_nxt = REPOSO;
      campo_nxt  = 2'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= REPOSO;
      campo       <= 2'd0;
      conf_activa <= 1'b0;
      // Capture live levels so a button held through reset release is not a press
      prev        <= btn;
`ifdef CONF_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      estado      <= estado_nxt;
      campo       <= campo_nxt;
      conf_activa <= (estado_nxt != REPOSO);
      prev        <= btn;
`ifdef CONF_TIMEOUT_EN
      if (any_press || timeout || estado == REPOSO)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
`endif
    end
  end

  assign funcion_conf = estado;

`ifndef CONF_TIMEOUT_EN
  logic unused_ok;
  assign unused_ok = any_press;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_funcion_conf.sv
// Directed bench for control_funcion_conf; expected outputs queued at drive time, checked one edge later.
`default_nettype none

module tb_control_funcion_conf;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_hora, btn_fecha, btn_timer, btn_campo, btn_salir;
  logic [2:0] funcion_conf;
  logic [1:0] campo;
  logic       conf_activa;

  int tests = 0;
  int fails = 0;
  int step  = 0;
  logic [5:0] exp_q[$];
  logic [5:0] got, want;

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_SALIR = 5'b10000;
  localparam logic [4:0] B_HORA  = 5'b01000;
  localparam logic [4:0] B_FECHA = 5'b00100;
  localparam logic [4:0] B_TIMER = 5'b00010;
  localparam logic [4:0] B_CAMPO = 5'b00001;

  localparam logic [2:0] F_IDLE  = 3'b000;
  localparam logic [2:0] F_HORA  = 3'b001;
  localparam logic [2:0] F_FECHA = 3'b010;
  localparam logic [2:0] F_TIMER = 3'b100;

`ifdef CONF_TIMEOUT_EN
  localparam logic [31:0] TO = 32'd16;
  localparam int          CW = 5;
`else
  localparam logic [31:0] TO = 32'd500_000_000;
  localparam int          CW = 29;
`endif

  control_funcion_conf #(.TIMEOUT_CICLOS(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_hora     (btn_hora),
    .btn_fecha    (btn_fecha),
    .btn_timer    (btn_timer),
    .btn_campo    (btn_campo),
    .btn_salir    (btn_salir),
    .funcion_conf (funcion_conf),
    .campo        (campo),
    .conf_activa  (conf_activa)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ex(input logic [2:0] f, input logic [1:0] c);
    return {f, c, (f != 3'b000)};
  endfunction

  // One clock: drive inputs, queue the expected post-edge outputs, check after the edge.
  task automatic cyc(input logic r, input logic [4:0] b, input logic [5:0] e);
    reset = r;
    {btn_salir, btn_hora, btn_fecha, btn_timer, btn_campo} = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {funcion_conf, campo, conf_activa};
    want = exp_q.pop_front();
    step++;
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL step %0d: observed fc/campo/act=%b expected %b", step, got, want);
    end
  endtask

  initial begin
    reset = 1'b1;
    {btn_salir, btn_hora, btn_fecha, btn_timer, btn_campo} = B_NONE;

    // Reset with btn_hora held, then hold it past release: no press
    cyc(1, B_HORA, ex(F_IDLE, 0));
    cyc(1, B_HORA, ex(F_IDLE, 0));
    cyc(0, B_HORA, ex(F_IDLE, 0));
    cyc(0, B_HORA, ex(F_IDLE, 0));
    cyc(0, B_NONE, ex(F_IDLE, 0));

    // Salir and campo ignored in REPOSO
    cyc(0, B_SALIR, ex(F_IDLE, 0));
    cyc(0, B_NONE,  ex(F_IDLE, 0));
    cyc(0, B_CAMPO, ex(F_IDLE, 0));
    cyc(0, B_NONE,  ex(F_IDLE, 0));

    // Fecha then five campo pulses: 1,2,3,0,1
    cyc(0, B_FECHA, ex(F_FECHA, 0));
    cyc(0, B_FECHA, ex(F_FECHA, 0));
    cyc(0, B_NONE,  ex(F_FECHA, 0));
    begin
      logic [1:0] seq_f [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 5; i++) begin
        cyc(0, B_CAMPO, ex(F_FECHA, seq_f[i]));
        cyc(0, B_NONE,  ex(F_FECHA, seq_f[i]));
      end
    end
    cyc(0, B_SALIR, ex(F_IDLE, 0));
    cyc(0, B_NONE,  ex(F_IDLE, 0));

    // Hora: campo wraps 1,2,0,1,2; then timer switch and timer toggle-off
    cyc(0, B_HORA, ex(F_HORA, 0));
    cyc(0, B_NONE, ex(F_HORA, 0));
    begin
      logic [1:0] seq_h [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      for (int i = 0; i < 5; i++) begin
        cyc(0, B_CAMPO, ex(F_HORA, seq_h[i]));
        cyc(0, B_NONE,  ex(F_HORA, seq_h[i]));
      end
    end
    cyc(0, B_TIMER, ex(F_TIMER, 0));
    cyc(0, B_NONE,  ex(F_TIMER, 0));
    cyc(0, B_TIMER, ex(F_IDLE, 0));
    cyc(0, B_NONE,  ex(F_IDLE, 0));

    // Timer: campo wrap at 3 fields, then salir+hora together -> REPOSO
    cyc(0, B_TIMER, ex(F_TIMER, 0));
    cyc(0, B_NONE,  ex(F_TIMER, 0));
    cyc(0, B_CAMPO, ex(F_TIMER, 1));
    cyc(0, B_NONE,  ex(F_TIMER, 1));
    cyc(0, B_CAMPO, ex(F_TIMER, 2));
    cyc(0, B_NONE,  ex(F_TIMER, 2));
    cyc(0, B_CAMPO, ex(F_TIMER, 0));
    cyc(0, B_NONE,  ex(F_TIMER, 0));
    cyc(0, B_SALIR | B_HORA, ex(F_IDLE, 0));
    cyc(0, B_SALIR | B_HORA, ex(F_IDLE, 0));
    cyc(0, B_NONE, ex(F_IDLE, 0));

    // Priority among simultaneous presses
    cyc(0, B_HORA | B_FECHA, ex(F_HORA, 0));
    cyc(0, B_NONE, ex(F_HORA, 0));
    cyc(0, B_CAMPO, ex(F_HORA, 1));
    cyc(0, B_NONE, ex(F_HORA, 1));
    cyc(0, B_HORA | B_FECHA, ex(F_IDLE, 0));
    cyc(0, B_NONE, ex(F_IDLE, 0));
    cyc(0, B_TIMER | B_CAMPO, ex(F_TIMER, 0));
    cyc(0, B_NONE, ex(F_TIMER, 0));
    cyc(0, B_FECHA | B_TIMER | B_CAMPO, ex(F_FECHA, 0));
    cyc(0, B_NONE, ex(F_FECHA, 0));

    // Reset mid-configuration with a button held through release
    cyc(0, B_CAMPO, ex(F_FECHA, 1));
    cyc(1, B_TIMER, ex(F_IDLE, 0));
    cyc(0, B_TIMER, ex(F_IDLE, 0));
    cyc(0, B_NONE,  ex(F_IDLE, 0));

`ifdef CONF_TIMEOUT_EN
    // Idle in CONF_HORA: exit exactly 16 edges after entry
    cyc(0, B_HORA, ex(F_HORA, 0));
    for (int i = 1; i < 16; i++) cyc(0, B_NONE, ex(F_HORA, 0));
    cyc(0, B_NONE, ex(F_IDLE, 0));
    cyc(0, B_NONE, ex(F_IDLE, 0));
    // Campo pulse at cycle 10 restarts the 16-cycle window
    cyc(0, B_HORA, ex(F_HORA, 0));
    for (int i = 1; i < 10; i++) cyc(0, B_NONE, ex(F_HORA, 0));
    cyc(0, B_CAMPO, ex(F_HORA, 1));
    for (int i = 1; i < 16; i++) cyc(0, B_NONE, ex(F_HORA, 1));
    cyc(0, B_NONE, ex(F_IDLE, 0));
`else
    // Without the timeout, configuration persists indefinitely
    cyc(0, B_FECHA, ex(F_FECHA, 0));
    for (int i = 0; i < 1000; i++) cyc(0, B_NONE, ex(F_FECHA, 0));
    cyc(0, B_SALIR, ex(F_IDLE, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
